// File: rtl/uart_pkg.sv
// Shared UART receive types and elaboration-time helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_t;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
    int den;
    int d;
    den = baud_rate * oversample;
    d   = (clk_freq + den / 2) / den;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: data_out shows the head combinationally, a push lands on the next edge.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              data_in,
  output logic                          full,
  input  logic                          pop,
  output logic [WIDTH-1:0]              data_out,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver into a FWFT FIFO; a word appears the clock after its stop-bit sample, full FIFO drops frames.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity); otherwise parity_err is tied 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               uart_rxd,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [count_width(FIFO_DEPTH)-1:0] rx_count,
  output logic                               frame_err,
  output logic                               overrun_err,
  output logic                               parity_err,
  input  logic                               err_clr
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PAR_ODD = (PARITY_ODD != 0);

  uart_rx_state_t       state;
  logic [1:0]           sync_q;
  logic                 rxs;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TCK_W-1:0]     tick_cnt;
  logic [TCK_W-1:0]     tick_goal;
  logic                 sample;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_bad;
  logic                 push_req;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 stop_bad;
  logic                 par_bad;
  logic                 frame_q;
  logic                 overrun_q;
  logic                 parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], uart_rxd};
  end
  assign rxs = sync_q[1];

  // Restarting the divider on the start edge keeps the samples centred on each bit.
  assign tick = (div_cnt == DIV_W'(DIV - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               div_cnt <= '0;
    else if (tick || (state == IDLE && !rxs)) div_cnt <= '0;
    else                                    div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick_goal = (state == START) ? TCK_W'(OVERSAMPLE / 2 - 1) : TCK_W'(OVERSAMPLE - 1);
  assign sample    = tick && (tick_cnt == tick_goal);

  assign pop      = rx_valid & rx_ready;
  assign push_req = (state == STOP) && sample && rxs && !frame_bad;
  assign stop_bad = (state == STOP) && sample && !rxs;
  assign par_bad  = (state == PARITY) && sample && (rxs != ((^shreg) ^ PAR_ODD));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_bad <= 1'b0;
    end else begin
      if (tick) tick_cnt <= sample ? '0 : tick_cnt + TCK_W'(1);
      case (state)
        IDLE: if (!rxs) begin
          state     <= START;
          tick_cnt  <= '0;
          frame_bad <= 1'b0;
        end
        START: if (sample) begin
          if (rxs) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: if (sample) begin
          shreg   <= {rxs, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) state <= PAR_EN ? PARITY : STOP;
        end
        PARITY: if (sample) begin
          if (par_bad) frame_bad <= 1'b1;
          state <= STOP;
        end
        // Leave mid stop bit so a back-to-back start edge is not missed.
        STOP: if (sample) state <= rxs ? IDLE : BREAK;
        BREAK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q   <= 1'b0;
      overrun_q <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      frame_q   <= stop_bad | (frame_q & ~err_clr);
      overrun_q <= (push_req & fifo_full & ~pop) | (overrun_q & ~err_clr);
      parity_q  <= par_bad | (parity_q & ~err_clr);
    end
  end

  assign frame_err   = frame_q;
  assign overrun_err = overrun_q;
  assign parity_err  = PAR_EN & parity_q;
  assign rx_valid    = ~fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .data_in  (shreg),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (rx_data),
    .empty    (fifo_empty),
    .count    (rx_count)
  );

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with oversampled start-bit validation, configurable data width and a first-word-fall-through receive FIFO. It replaces the fixed 8N1 receive path behind each `uart_rxd`/`uart_rxd1` pin of `system`. It sits between the pad and the CPU-side register interface, and reports framing, overrun and optional parity errors.

## Interface
Parameters:
- `CLK_FREQ`, 50000000, system clock in Hz
- `BAUD_RATE`, 115200, line rate in baud
- `OVERSAMPLE`, 16, ticks per bit; must be even and ≥ 8
- `DATA_BITS`, 8, data bits per frame, 5..9
- `FIFO_DEPTH`, 16, receive FIFO entries; must be a power of 2, ≥ 2
- `PARITY_ODD`, 0, 0 = even parity, 1 = odd; used only with `UART_PARITY_EN`

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous assert, active-low
- `uart_rxd` in 1: serial line, idle high, asynchronous to `clk`
- `rx_data` out `DATA_BITS`: FIFO head word
- `rx_valid` out 1: FIFO not empty
- `rx_ready` in 1: consumer accepts head word
- `rx_count` out `$clog2(FIFO_DEPTH)+1`: FIFO occupancy
- `frame_err` out 1: sticky, stop bit sampled low
- `overrun_err` out 1: sticky, frame dropped because FIFO full
- `parity_err` out 1: sticky, parity mismatch
- `err_clr` in 1: clears all sticky errors

## Operation
- Tick generator: divider `DIV = round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE))`, one-cycle tick every `DIV` clocks. The divider is free-running except that it restarts on start-edge detection.
- `uart_rxd` passes through a 2-flop synchroniser; both flops reset to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: synced line low → START; tick counter cleared.
- START: at tick `OVERSAMPLE/2-1`, sample the line. If high (glitch) → IDLE. If low → DATA, bit counter = 0.
- DATA: sample every `OVERSAMPLE` ticks, LSB first, into a shift register. After `DATA_BITS` samples → PARITY if the macro is defined, else STOP.
- PARITY: sample one bit and compare it with the XOR of the data bits, plus `PARITY_ODD`. On mismatch, set `parity_err` and mark the frame bad. Then → STOP.
- STOP: sample one bit.
  - Low: set `frame_err`, discard the frame, → BREAK.
  - High and frame good: push to the FIFO if not full; if full, set `overrun_err` and drop the frame. In both cases → IDLE immediately after the sample, which tolerates back-to-back frames.
  - High and frame bad (parity): drop the frame, → IDLE.
- BREAK: wait for the synced line to go high → IDLE.
- FIFO:
  - Pop = `rx_valid & rx_ready`.
  - Push and pop in the same cycle while full: push accepted, count unchanged, no overrun.
  - Pop while empty: ignored.
- `rx_data` is don't-care while `rx_valid` is 0 (implementation holds the last value).
- Sticky errors: set has priority over `err_clr` in the same cycle.

## Timing
- Reset values: `rx_valid` = 0, `rx_count` = 0, `rx_data` = 0, all errors = 0, FSM = IDLE, synchroniser = 1.
- Reset mid-frame aborts the frame and flushes the FIFO; the next complete frame is received normally.
- Line edge to FSM visibility: 2 clocks.
- Stop-bit sample tick → `rx_valid`/`rx_count` updated on the next clock edge.
- Pop takes effect at the clock edge; the new head word is valid one cycle later.
- Error flags assert on the clock edge after the offending sample tick.
- Sampling point: mid-bit ±1 tick. A frame tolerates ±2 % baud mismatch at `OVERSAMPLE` = 16.

## Configuration
- `UART_PARITY_EN` defined: PARITY state present. Frame = start + `DATA_BITS` + parity + stop. Mismatch sets `parity_err` and drops the frame.
- Not defined: no PARITY state. Frame = start + `DATA_BITS` + stop. `parity_err` is tied 0.

## Structure
- Package `uart_pkg`: FSM state typedef `uart_rx_state_t`, the divider-rounding function, and a `$clog2`-based count-width constant function.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`), first-word-fall-through. Interface: push/data_in/full, pop/data_out/empty, count. It is reusable later for the TX path.
- The synchroniser, tick generator and FSM stay inline in `uart_rx_fifo`.

## Test plan
- 50 MHz, 115200 baud, 8N1 frame 0x55 → after the stop bit, `rx_data` = 0x55, `rx_valid` = 1, `rx_count` = 1; `rx_ready` pulse → `rx_count` = 0.
- 17 back-to-back frames 0x00..0x10, `rx_ready` = 0 → `rx_count` = 16, `overrun_err` = 1; drain yields 0x00..0x0F in order.
- Low glitch of 5 ticks (< half bit) → no push, FSM back to IDLE. A following 0xA3 is received correctly.
- Frame 0x3C with stop bit 0, line held low for 3 bit times → `frame_err` = 1, no push. After the line goes high, 0x81 is received. `err_clr` → `frame_err` = 0.
- With `UART_PARITY_EN`, `PARITY_ODD` = 0: 0x07 with parity bit 0 → `parity_err` = 1, `rx_count` = 0. 0x07 with parity bit 1 → byte accepted.
- `rst` low during data bit 4 → all outputs at reset values. After release, 0xC6 → `rx_data` = 0xC6, `rx_count` = 1.
